// File: rtl/decoder_pkg.sv
// Shared definitions for the Keccak-f inverse-round decoder: controller states,
// inverse-step identifiers and default sizing. Used by the controller, the datapath
// and the bench.
package decoder_pkg;

    localparam int unsigned NUM_ROUNDS_DEF = 24;
    localparam int unsigned TIMEOUT_DEF    = 4095;
    localparam int unsigned IDX_W_DEF      = 10;
    localparam int unsigned ITER_W_DEF     = 5;
    localparam int unsigned NUM_STEPS      = 5;
    localparam int unsigned STATE_W        = 3;

    // Controller states, kept as plain constants so older tools can share them
    localparam logic [STATE_W-1:0] S_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] S_LAUNCH = 3'd1;
    localparam logic [STATE_W-1:0] S_WAIT   = 3'd2;
    localparam logic [STATE_W-1:0] S_DONE   = 3'd3;
    localparam logic [STATE_W-1:0] S_ERR    = 3'd4;

    // Inverse steps in execution order within one round
    typedef enum logic [2:0] {
        STEP_RC = 3'd0,   // iota^-1
        STEP_RE = 3'd1,   // chi^-1
        STEP_PE = 3'd2,   // pi^-1
        STEP_RO = 3'd3,   // rho^-1
        STEP_CP = 3'd4    // theta^-1
    } step_e;

    // Successor step within a round; CP wraps to RC
    function automatic step_e next_step(input step_e s);
        case (s)
            STEP_RC: return STEP_RE;
            STEP_RE: return STEP_PE;
            STEP_PE: return STEP_RO;
            STEP_RO: return STEP_CP;
            default: return STEP_RC;
        endcase
    endfunction

    // One-hot select vector, bit order {CP,RO,PE,RE,RC}
    function automatic logic [NUM_STEPS-1:0] step_onehot(input step_e s);
        return {{(NUM_STEPS-1){1'b0}}, 1'b1} << s;
    endfunction

endpackage

// File: rtl/decoder_controller_if.sv
// Bundle between the decoder controller, its requester and the five inverse-step modules.
//   start/abort/file_base/file_count : run request from the requester
//   busy/done/error                  : run status back to the requester
//   file_index/iteration             : shared buses to the step modules
//   *_start / *_finish               : per-step handshakes
// master = requester + step modules side, slave = controller side.
interface decoder_controller_if #(
    parameter int unsigned IDX_W  = 10,
    parameter int unsigned ITER_W = 5
) ();

    logic              start;
    logic              abort;
    logic [IDX_W-1:0]  file_base;
    logic [IDX_W-1:0]  file_count;
    logic              busy;
    logic              done;
    logic              error;
    logic [IDX_W-1:0]  file_index;
    logic [ITER_W-1:0] iteration;
    logic              RC_start, RE_start, PE_start, RO_start, CP_start;
    logic              RC_finish, RE_finish, PE_finish, RO_finish, CP_finish;

    modport master (
        output start, abort, file_base, file_count,
        output RC_finish, RE_finish, PE_finish, RO_finish, CP_finish,
        input  busy, done, error, file_index, iteration,
        input  RC_start, RE_start, PE_start, RO_start, CP_start
    );

    modport slave (
        input  start, abort, file_base, file_count,
        input  RC_finish, RE_finish, PE_finish, RO_finish, CP_finish,
        output busy, done, error, file_index, iteration,
        output RC_start, RE_start, PE_start, RO_start, CP_start
    );

endinterface

// File: rtl/decoder_controller_step_watchdog.sv
// Per-step timeout counter.
//   clk, rst     : clock, asynchronous active-low reset
//   i_clear      : restart the count (asserted while a step is launched)
//   i_enable     : count one cycle spent waiting for the step's finish
//   o_expired_c  : the current waiting cycle is the TIMEOUT-th one (combinational)
module step_watchdog #(
    parameter int unsigned TIMEOUT = 4095
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_cnt;

    // Count holds at the limit; the controller leaves WAIT on expiry anyway
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && !o_expired_c) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // r_cnt equals the number of WAIT cycles already completed
    assign o_expired_c = i_enable && (r_cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/decoder_controller.sv
// Sequencer for the Keccak-f inverse round. For every file in [file_base, file_base+file_count)
// it runs rounds NUM_ROUNDS-1 .. 0, each as RC, RE, PE, RO, CP steps, pulsing the step's start
// and waiting for its finish.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : decoder_controller_if slave (request, status, step handshakes, index buses)
module decoder_controller
    import decoder_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS = NUM_ROUNDS_DEF,
    parameter int unsigned IDX_W      = IDX_W_DEF,
    parameter int unsigned ITER_W     = ITER_W_DEF,
    parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    decoder_controller_if.slave  bus
);

    logic [STATE_W-1:0]   r_state,      w_state;
    step_e                r_step,       w_step;
    logic [IDX_W-1:0]     r_file_index, w_file_index;
    logic [IDX_W-1:0]     r_files_left, w_files_left;
    logic [ITER_W-1:0]    r_iteration,  w_iteration;
    logic                 r_busy,       w_busy;
    logic                 r_done,       w_done;
    logic                 r_error,      w_error;
    logic [NUM_STEPS-1:0] r_start,      w_start;
    logic                 w_launch;
    logic [NUM_STEPS-1:0] w_finish_vec;
    logic                 w_finish_c;
    logic                 w_expired_c;

    // Only the active step's finish is observed
    assign w_finish_vec = {bus.CP_finish, bus.RO_finish, bus.PE_finish, bus.RE_finish, bus.RC_finish};
    assign w_finish_c   = |(w_finish_vec & step_onehot(r_step));

    step_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (r_state == S_LAUNCH),
        .i_enable    (r_state == S_WAIT),
        .o_expired_c (w_expired_c)
    );

    // Next state and next registered outputs
    always_comb begin
        w_state      = r_state;
        w_step       = r_step;
        w_file_index = r_file_index;
        w_files_left = r_files_left;
        w_iteration  = r_iteration;
        w_busy       = r_busy;
        w_done       = 1'b0;
        w_error      = r_error;
        w_start      = '0;
        w_launch     = 1'b0;

        if ((r_state != S_IDLE) && bus.abort) begin
            // abort outranks finish and timeout; error is left as is
            w_state = S_IDLE;
            w_busy  = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        w_file_index = bus.file_base;
                        w_files_left = bus.file_count;
                        w_iteration  = ITER_W'(NUM_ROUNDS - 1);
                        w_step       = STEP_RC;
                        w_busy       = 1'b1;
                        w_error      = 1'b0;
                        if (bus.file_count == '0) begin
                            w_state = S_DONE;
                            w_done  = 1'b1;
                        end else begin
                            w_launch = 1'b1;
                        end
                    end
                end
                S_LAUNCH: begin
                    w_state = S_WAIT;
                end
                S_WAIT: begin
                    if (w_finish_c) begin
                        if (r_step != STEP_CP) begin
                            w_step   = next_step(r_step);
                            w_launch = 1'b1;
                        end else if (r_iteration != '0) begin
                            w_iteration = r_iteration - ITER_W'(1);
                            w_step      = STEP_RC;
                            w_launch    = 1'b1;
                        end else if (r_files_left > IDX_W'(1)) begin
                            // file index is allowed to wrap at IDX_W bits
                            w_files_left = r_files_left - IDX_W'(1);
                            w_file_index = r_file_index + IDX_W'(1);
                            w_iteration  = ITER_W'(NUM_ROUNDS - 1);
                            w_step       = STEP_RC;
                            w_launch     = 1'b1;
                        end else begin
                            w_state = S_DONE;
                            w_done  = 1'b1;
                        end
                    end else if (w_expired_c) begin
                        w_state = S_ERR;
                        w_error = 1'b1;
                        w_busy  = 1'b0;
                    end
                end
                S_DONE: begin
                    w_state = S_IDLE;
                    w_busy  = 1'b0;
                end
                S_ERR: begin
                    w_state = S_IDLE;
                end
                default: begin
                    w_state = S_IDLE;
                    w_busy  = 1'b0;
                end
            endcase
        end

        if (w_launch) begin
            w_state = S_LAUNCH;
            w_start = step_onehot(w_step);
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_step       <= STEP_RC;
            r_file_index <= '0;
            r_files_left <= '0;
            r_iteration  <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_start      <= '0;
        end else begin
            r_state      <= w_state;
            r_step       <= w_step;
            r_file_index <= w_file_index;
            r_files_left <= w_files_left;
            r_iteration  <= w_iteration;
            r_busy       <= w_busy;
            r_done       <= w_done;
            r_error      <= w_error;
            r_start      <= w_start;
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.error      = r_error;
    assign bus.file_index = r_file_index;
    assign bus.iteration  = r_iteration;
    assign bus.RC_start   = r_start[0];
    assign bus.RE_start   = r_start[1];
    assign bus.PE_start   = r_start[2];
    assign bus.RO_start   = r_start[3];
    assign bus.CP_start   = r_start[4];

endmodule
